// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-port ALU arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Bit positions inside the 4-bit flags word
  localparam int FLAG_COUT = 3;
  localparam int FLAG_NEG  = 2;
  localparam int FLAG_ZERO = 1;
  localparam int FLAG_OVF  = 0;

  // ALU operation codes; any other code yields Y = 0
  localparam logic [3:0] OP_ADD   = 4'h0;  // A + B + Cin
  localparam logic [3:0] OP_SUB   = 4'h1;  // A + ~B + Cin (Cin=1 gives A - B)
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_NOT_A = 4'h5;
  localparam logic [3:0] OP_PASSA = 4'h6;
  localparam logic [3:0] OP_PASSB = 4'h7;

  // Port chosen from the two valids: a lone valid wins, a collision goes to prio
  function automatic logic pick_port(input logic v0, input logic v1, input logic prio);
    if (v0 && v1) return prio;
    return v1;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle for both requesters of the ALU arbiter.
// Latency: none (wiring only).
// Backpressure: req side uses valid/ready, rsp side uses valid/ready.
interface alu_arbiter_if #(
  parameter int W = 32
);
  logic         req0_valid, req0_ready, req0_cin;
  logic [3:0]   req0_sel;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_cin;
  logic [3:0]   req1_sel;
  logic [W-1:0] req1_a, req1_b;

  logic         rsp0_valid, rsp0_ready;
  logic [W-1:0] rsp0_y;
  logic [3:0]   rsp0_flags;
  logic         rsp1_valid, rsp1_ready;
  logic [W-1:0] rsp1_y;
  logic [3:0]   rsp1_flags;

  // Requester side
  modport master (
    output req0_valid, req0_sel, req0_a, req0_b, req0_cin,
    output req1_valid, req1_sel, req1_a, req1_b, req1_cin,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_y, rsp0_flags,
    input  rsp1_valid, rsp1_y, rsp1_flags,
    output rsp0_ready, rsp1_ready
  );

  // Arbiter side
  modport slave (
    input  req0_valid, req0_sel, req0_a, req0_b, req0_cin,
    input  req1_valid, req1_sel, req1_a, req1_b, req1_cin,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_y, rsp0_flags,
    output rsp1_valid, rsp1_y, rsp1_flags,
    input  rsp0_ready, rsp1_ready
  );
endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational W-bit ALU producing Y and {Cout, Negative, Zero, Overflow}.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers the result.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [3:0]   sel_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] y_o,
  output logic [3:0]   flags_o
);
  logic [W:0] sum;
  logic       cout;
  logic       ovf;

  // Operation decode; carry and overflow only mean something for ADD/SUB
  always_comb begin
    sum     = '0;
    y_o     = '0;
    cout    = 1'b0;
    ovf     = 1'b0;
    flags_o = '0;
    case (sel_i)
      OP_ADD: begin
        sum  = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};
        y_o  = sum[W-1:0];
        cout = sum[W];
        ovf  = (a_i[W-1] == b_i[W-1]) && (y_o[W-1] != a_i[W-1]);
      end
      OP_SUB: begin
        sum  = {1'b0, a_i} + {1'b0, ~b_i} + {{W{1'b0}}, cin_i};
        y_o  = sum[W-1:0];
        cout = sum[W];
        ovf  = (a_i[W-1] != b_i[W-1]) && (y_o[W-1] != a_i[W-1]);
      end
      OP_AND:   y_o = a_i & b_i;
      OP_OR:    y_o = a_i | b_i;
      OP_XOR:   y_o = a_i ^ b_i;
      OP_NOT_A: y_o = ~a_i;
      OP_PASSA: y_o = a_i;
      OP_PASSB: y_o = b_i;
      default:  y_o = '0;
    endcase
    flags_o[FLAG_COUT] = cout;
    flags_o[FLAG_NEG]  = y_o[W-1];
    flags_o[FLAG_ZERO] = (y_o == '0);
    flags_o[FLAG_OVF]  = ovf;
  end
endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU under round-robin priority, one op in flight.
// Latency: accepted in cycle T, response valid in T+2; at least 3 cycles per op.
// Backpressure: a stalled response holds RESP and blocks all new requests.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int RR_INIT = 0,
  parameter int W       = 32
) (
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);
  state_e       state_q;
  logic         prio_q;
  logic         grant_q;
  logic [3:0]   sel_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic         cin_q;
  logic [W-1:0] y_q;
  logic [3:0]   flags_q;
  logic [1:0]   rsp_vld_q;

  logic         any_req;
  logic         pick;
  logic         accept;
  logic         rsp_done;
  logic [W-1:0] alu_y;
  logic [3:0]   alu_flags;

  // Grant decision; ready is combinational so the winner sees it in the accept cycle
  always_comb begin
    any_req  = bus.req0_valid | bus.req1_valid;
    pick     = pick_port(bus.req0_valid, bus.req1_valid, prio_q);
    accept   = !rst && (state_q == ST_IDLE) && any_req;
    rsp_done = (state_q == ST_RESP) && (grant_q ? bus.rsp1_ready : bus.rsp0_ready);
  end

  assign bus.req0_ready = accept & ~pick;
  assign bus.req1_ready = accept & pick;

  // Response data is forced to zero on the port that is not presenting a result
  assign bus.rsp0_valid = rsp_vld_q[0];
  assign bus.rsp1_valid = rsp_vld_q[1];
  assign bus.rsp0_y     = rsp_vld_q[0] ? y_q : '0;
  assign bus.rsp1_y     = rsp_vld_q[1] ? y_q : '0;
  assign bus.rsp0_flags = rsp_vld_q[0] ? flags_q : '0;
  assign bus.rsp1_flags = rsp_vld_q[1] ? flags_q : '0;

  alu_arbiter_alu #(.W(W)) u_alu (
    .sel_i   (sel_q),
    .a_i     (a_q),
    .b_i     (b_q),
    .cin_i   (cin_q),
    .y_o     (alu_y),
    .flags_o (alu_flags)
  );

  // Operation FSM: capture operands, execute once from registers, hold result until consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      prio_q    <= (RR_INIT != 0);
      grant_q   <= 1'b0;
      sel_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cin_q     <= 1'b0;
      y_q       <= '0;
      flags_q   <= '0;
      rsp_vld_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            grant_q <= pick;
            sel_q   <= pick ? bus.req1_sel : bus.req0_sel;
            a_q     <= pick ? bus.req1_a   : bus.req0_a;
            b_q     <= pick ? bus.req1_b   : bus.req0_b;
            cin_q   <= pick ? bus.req1_cin : bus.req0_cin;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          y_q       <= alu_y;
          flags_q   <= alu_flags;
          rsp_vld_q <= grant_q ? 2'b10 : 2'b01;
          state_q   <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_done) begin
            rsp_vld_q <= '0;
            y_q       <= '0;
            flags_q   <= '0;
            prio_q    <= ~grant_q;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, directed corner cases, random vs model.
// Latency: checks the accept -> T+2 response timing on every operation.
// Backpressure: exercises response stalls and request holding.
`timescale 1ns/1ps
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_arbiter_if #(.W(W)) bus ();

  alu_arbiter #(.RR_INIT(0), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference ALU from plain arithmetic on wide integers
  function automatic logic [35:0] model(input logic [3:0] sel, input logic [31:0] a,
                                        input logic [31:0] b, input logic cin);
    longint unsigned ua, ub, us;
    longint          sa, sb, ss;
    logic [31:0]     y;
    logic            c, v;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    y = 32'h0; c = 1'b0; v = 1'b0;
    case (sel)
      4'd0: begin
        us = ua + ub + cin; y = us[31:0]; c = us[32];
        ss = sa + sb + cin;
        v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      4'd1: begin
        us = ua + (64'hFFFF_FFFF - ub) + cin; y = us[31:0]; c = us[32];
        ss = sa - sb - 1 + cin;
        v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      4'd2: y = a & b;
      4'd3: y = a | b;
      4'd4: y = a ^ b;
      4'd5: y = ~a;
      4'd6: y = a;
      4'd7: y = b;
      default: y = 32'h0;
    endcase
    return {c, y[31], (y == 32'h0), v, y};
  endfunction

  function automatic logic get_ready(input int p);
    return (p != 0) ? bus.req1_ready : bus.req0_ready;
  endfunction
  function automatic logic get_rvld(input int p);
    return (p != 0) ? bus.rsp1_valid : bus.rsp0_valid;
  endfunction
  function automatic logic [31:0] get_y(input int p);
    return (p != 0) ? bus.rsp1_y : bus.rsp0_y;
  endfunction
  function automatic logic [3:0] get_f(input int p);
    return (p != 0) ? bus.rsp1_flags : bus.rsp0_flags;
  endfunction

  task automatic set_req(input int p, input logic v, input logic [3:0] s,
                         input logic [31:0] a, input logic [31:0] b, input logic c);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_sel = s; bus.req0_a = a; bus.req0_b = b; bus.req0_cin = c;
    end else begin
      bus.req1_valid = v; bus.req1_sel = s; bus.req1_a = a; bus.req1_b = b; bus.req1_cin = c;
    end
  endtask

  task automatic set_rsp_ready(input int p, input logic r);
    if (p == 0) bus.rsp0_ready = r;
    else        bus.rsp1_ready = r;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  // One isolated operation on port p; payload is scrambled right after acceptance
  task automatic do_op(input int p, input logic [3:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic cin,
                       output logic [31:0] y, output logic [3:0] f);
    int n;
    @(negedge clk);
    set_req(p, 1'b1, sel, a, b, cin);
    #1;
    n = 0;
    while (!get_ready(p) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk($sformatf("op_p%0d_ready", p), get_ready(p), 1);
    chk($sformatf("op_p%0d_other_ready", p), get_ready(1 - p), 0);
    @(negedge clk);
    set_req(p, 1'b0, ~sel, ~a, ~b, ~cin);
    #1;
    chk($sformatf("op_p%0d_rvld_T1", p), get_rvld(p), 0);
    @(negedge clk); #1;
    chk($sformatf("op_p%0d_rvld_T2", p), get_rvld(p), 1);
    chk($sformatf("op_p%0d_other_rvld", p), get_rvld(1 - p), 0);
    y = get_y(p);
    f = get_f(p);
    @(negedge clk); #1;
    chk($sformatf("op_p%0d_rvld_after", p), get_rvld(p), 0);
    chk($sformatf("op_p%0d_y_after", p), get_y(p), 0);
  endtask

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] y;
    logic [3:0]  f;
  } vec_t;

  vec_t        vecs[12];
  logic [31:0] ry;
  logic [3:0]  rf;
  logic [35:0] mexp;

  // Random-phase model state
  logic        rv[2];
  logic [3:0]  rs[2];
  logic [31:0] ra[2], rb[2];
  logic        rc[2];
  logic        rr[2];
  logic        busy;
  int          gp, since, last, w;
  logic [1:0]  exp_r, exp_v;
  logic [31:0] ey;
  logic [3:0]  ef;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{OP_AND,   32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 32'h00F000F0, 4'b0000};
    vecs[1]  = '{OP_XOR,   32'h12345678, 32'h12345678, 1'b0, 32'h00000000, 4'b0010};
    vecs[2]  = '{OP_ADD,   32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 4'b1010};
    vecs[3]  = '{OP_ADD,   32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 4'b0101};
    vecs[4]  = '{OP_SUB,   32'h00000005, 32'h00000003, 1'b1, 32'h00000002, 4'b1000};
    vecs[5]  = '{OP_SUB,   32'h00000003, 32'h00000005, 1'b1, 32'hFFFFFFFE, 4'b0100};
    vecs[6]  = '{OP_OR,    32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 4'b0010};
    vecs[7]  = '{OP_NOT_A, 32'h00000000, 32'h12345678, 1'b0, 32'hFFFFFFFF, 4'b0100};
    vecs[8]  = '{OP_PASSB, 32'h00001234, 32'h80000000, 1'b0, 32'h80000000, 4'b0100};
    vecs[9]  = '{4'hF,     32'h0000FFFF, 32'h0000FFFF, 1'b1, 32'h00000000, 4'b0010};
    vecs[10] = '{OP_SUB,   32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 4'b1001};
    vecs[11] = '{OP_ADD,   32'h00000001, 32'h00000001, 1'b1, 32'h00000003, 4'b0000};

    // Reset state, with a request already waiting
    rst = 1'b1;
    set_req(0, 1'b1, OP_ADD, 32'd2, 32'd3, 1'b0);
    set_req(1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready0", bus.req0_ready, 0);
    chk("rst_ready1", bus.req1_ready, 0);
    chk("rst_rvld", {bus.rsp1_valid, bus.rsp0_valid}, 2'b00);
    chk("rst_y0", bus.rsp0_y, 0);
    chk("rst_f1", bus.rsp1_flags, 0);

    // First acceptance in the first cycle with rst low
    @(negedge clk); rst = 1'b0; #1;
    chk("first_accept_ready0", bus.req0_ready, 1);
    @(negedge clk); set_req(0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk); #1;
    chk("first_rvld0", bus.rsp0_valid, 1);
    chk("first_y0", bus.rsp0_y, 32'd5);
    @(negedge clk);

    // Vector table, alternating ports
    for (int i = 0; i < 12; i++) begin
      do_op(i % 2, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].cin, ry, rf);
      chk($sformatf("vec%0d_y", i), ry, vecs[i].y);
      chk($sformatf("vec%0d_flags", i), rf, vecs[i].f);
    end

    // Collision after reset: req0 wins, req1 held, then priority alternates
    do_reset();
    @(negedge clk);
    set_req(0, 1'b1, OP_ADD, 32'd1, 32'd2, 1'b0);
    set_req(1, 1'b1, OP_ADD, 32'd10, 32'd20, 1'b0);
    #1;
    chk("col_a_ready0", bus.req0_ready, 1);
    chk("col_a_ready1", bus.req1_ready, 0);
    @(negedge clk); set_req(0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0); #1;
    chk("col_exec_ready1", bus.req1_ready, 0);
    @(negedge clk); #1;
    chk("col_rsp0_valid", bus.rsp0_valid, 1);
    chk("col_rsp0_y", bus.rsp0_y, 32'd3);
    chk("col_resp_ready1", bus.req1_ready, 0);
    chk("col_rsp1_idle", bus.rsp1_valid, 0);
    @(negedge clk); set_req(0, 1'b1, OP_ADD, 32'd5, 32'd6, 1'b0); #1;
    chk("col_b_ready1", bus.req1_ready, 1);
    chk("col_b_ready0", bus.req0_ready, 0);
    @(negedge clk); set_req(1, 1'b1, OP_ADD, 32'd100, 32'd200, 1'b0); #1;
    chk("col_b_exec_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
    @(negedge clk); #1;
    chk("col_rsp1_valid", bus.rsp1_valid, 1);
    chk("col_rsp1_y", bus.rsp1_y, 32'd30);
    @(negedge clk); #1;
    chk("col_c_ready", {bus.req1_ready, bus.req0_ready}, 2'b01);
    @(negedge clk); set_req(0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk); #1;
    chk("col_c_rsp0_y", bus.rsp0_y, 32'd11);
    @(negedge clk); #1;
    chk("col_d_ready1", bus.req1_ready, 1);
    @(negedge clk); set_req(1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk); #1;
    chk("col_d_rsp1_y", bus.rsp1_y, 32'd300);
    @(negedge clk);

    // Response backpressure: result held, other requester locked out
    mexp = model(OP_SUB, 32'h1000, 32'h1, 1'b1);
    @(negedge clk);
    set_rsp_ready(0, 1'b0);
    set_req(0, 1'b1, OP_SUB, 32'h1000, 32'h1, 1'b1);
    #1;
    chk("bp_ready0", bus.req0_ready, 1);
    @(negedge clk);
    set_req(0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    set_req(1, 1'b1, OP_OR, 32'hA0, 32'h05, 1'b0);
    #1;
    chk("bp_exec_ready1", bus.req1_ready, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk($sformatf("bp%0d_rvld0", k), bus.rsp0_valid, 1);
      chk($sformatf("bp%0d_y0", k), bus.rsp0_y, mexp[31:0]);
      chk($sformatf("bp%0d_f0", k), bus.rsp0_flags, mexp[35:32]);
      chk($sformatf("bp%0d_ready1", k), bus.req1_ready, 0);
    end
    set_rsp_ready(0, 1'b1);
    @(negedge clk); #1;
    chk("bp_done_rvld0", bus.rsp0_valid, 0);
    chk("bp_done_y0", bus.rsp0_y, 0);
    chk("bp_done_ready1", bus.req1_ready, 1);
    @(negedge clk); set_req(1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk); #1;
    chk("bp_rsp1_y", bus.rsp1_y, 32'hA5);
    @(negedge clk);

    // Reset during EXEC drops the in-flight operation
    @(negedge clk);
    set_req(0, 1'b1, OP_ADD, 32'h11, 32'h22, 1'b0);
    #1;
    chk("rx_ready0", bus.req0_ready, 1);
    @(negedge clk);
    set_req(0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rx%0d_rvld", k), {bus.rsp1_valid, bus.rsp0_valid}, 2'b00);
      chk($sformatf("rx%0d_y0", k), bus.rsp0_y, 0);
      chk($sformatf("rx%0d_f0", k), bus.rsp0_flags, 0);
      @(negedge clk);
    end
    do_op(0, OP_ADD, 32'd7, 32'd8, 1'b0, ry, rf);
    chk("rx_next_y", ry, 32'd15);
    chk("rx_next_f", rf, 4'b0000);

    // Random traffic against the reference model
    do_reset();
    busy = 1'b0; since = 0; gp = 0; last = 1; w = 0;
    for (int p = 0; p < 2; p++) begin
      rv[p] = 1'b0; rs[p] = 4'h0; ra[p] = 32'h0; rb[p] = 32'h0; rc[p] = 1'b0; rr[p] = 1'b1;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (!rv[p] && $urandom_range(0, 2) == 0) begin
          rv[p] = 1'b1;
          rs[p] = 4'($urandom_range(0, 9));
          ra[p] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom();
          rb[p] = ($urandom_range(0, 3) == 0) ? ra[p] : $urandom();
          rc[p] = 1'($urandom_range(0, 1));
        end
        set_req(p, rv[p], rs[p], ra[p], rb[p], rc[p]);
        rr[p] = ($urandom_range(0, 3) != 0);
        set_rsp_ready(p, rr[p]);
      end
      #1;
      exp_r = 2'b00;
      if (!busy && (rv[0] || rv[1])) begin
        w = (rv[0] && rv[1]) ? (1 - last) : (rv[1] ? 1 : 0);
        exp_r[w] = 1'b1;
      end
      chk("rnd_ready", {bus.req1_ready, bus.req0_ready}, exp_r);
      exp_v = 2'b00;
      if (busy && since >= 2) exp_v[gp] = 1'b1;
      chk("rnd_rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, exp_v);
      for (int p = 0; p < 2; p++) begin
        if (exp_v[p]) begin
          chk("rnd_y", get_y(p), ey);
          chk("rnd_flags", get_f(p), ef);
        end else begin
          chk("rnd_idle_yf", {get_f(p), get_y(p)}, 0);
        end
      end
      if (busy) begin
        if (since >= 2 && rr[gp]) begin
          busy = 1'b0;
          last = gp;
        end else begin
          since++;
        end
      end else if (exp_r != 2'b00) begin
        busy  = 1'b1;
        gp    = w;
        since = 1;
        {ef, ey} = model(rs[w], ra[w], rb[w], rc[w]);
        rv[w] = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
